// File: rtl/uart_image_loader_if.sv
// Byte-stream input, RAM write port and load status of the UART image loader.
interface uart_image_loader_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [15:0]           ram_wr_data;
  logic                  load_busy;
  logic                  load_done;
  logic                  load_err;

  modport master (
    output rx_data, rx_valid,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, load_busy, load_done, load_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output ram_wr_en, ram_wr_addr, ram_wr_data, load_busy, load_done, load_err
  );
endinterface

// File: rtl/uart_image_loader.sv
// Hunts for an A5 5A header in a UART byte stream, then packs byte pairs into
// RGB565 pixels written sequentially into the image RAM.
module uart_image_loader #(
  parameter int unsigned IMG_WIDTH      = 169,
  parameter int unsigned IMG_HEIGHT     = 267,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 3300000,
  parameter bit          MSB_FIRST      = 1'b1
) (
  input logic               clk_ctrl,
  input logic               rst_p,
  uart_image_loader_if.slave bus
);

  typedef enum logic [1:0] {HUNT, SYNC2, BYTE0, BYTE1} state_t;

  localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            byte_q, byte_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [15:0]           pixel;

  assign pixel = MSB_FIRST ? {byte_q, bus.rx_data} : {bus.rx_data, byte_q};

  always_ff @(posedge clk_ctrl or posedge rst_p) begin
    if (rst_p) begin
      state_q <= HUNT;
      idx_q   <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      HUNT: begin
        busy_d = 1'b0;
        if (bus.rx_valid && bus.rx_data == 8'hA5) state_d = SYNC2;
      end
      SYNC2: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h5A) begin
            state_d = BYTE0;
            idx_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
          end else if (bus.rx_data != 8'hA5) begin
            state_d = HUNT;
          end
        end
      end
      BYTE0, BYTE1: begin
        if (bus.rx_valid) begin
          cnt_d = '0;
          if (state_q == BYTE0) begin
            byte_d  = bus.rx_data;
            state_d = BYTE1;
          end else begin
            wr_en_d = 1'b1;
            addr_d  = ADDR_WIDTH'(idx_q);
            data_d  = pixel;
            // Last pixel finishes the load in the same cycle as its write.
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = HUNT;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = BYTE0;
            end
          end
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = HUNT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = addr_q;
  assign bus.ram_wr_data = data_q;
  assign bus.load_busy   = busy_q;
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;

endmodule
